// File: rtl/stack_control_unit.sv
// Three-cycle FETCH/DECODE/EXEC control unit for a stack machine. It latches the
// fetched word into IR, decodes the opcode and drives PC, return-stack, data-stack and ALU controls.
module stack_control_unit #(
    parameter int IMM_W = 12,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [IMM_W+3:0]   inst,
    input  logic               Overflow,
    input  logic               Zero,
    input  logic               Stall,
    output logic               PCWrite,
    output logic [2:0]         PCControl,
    output logic [1:0]         RStackOP,
    output logic [1:0]         DStackOP,
    output logic [2:0]         ALUOp,
    output logic               DSel,
    output logic               Halted,
    output logic               Fault,
    output logic [CNT_W-1:0]   InstRetired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        HALT   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_ALU   = 4'd2;
    localparam logic [3:0] OP_POP   = 4'd3;
    localparam logic [3:0] OP_DUP   = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_BZ    = 4'd6;
    localparam logic [3:0] OP_CALL  = 4'd7;
    localparam logic [3:0] OP_RET   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    state_t             state_reg;
    logic [IMM_W+3:0]   ir_reg;
    logic [CNT_W-1:0]   retired_reg;
    logic [3:0]         opcode;
    logic               call_overflow;
    logic               unused_imm;

    assign opcode        = ir_reg[IMM_W+3:IMM_W];
    assign call_overflow = (opcode == OP_CALL) && Overflow;
    // The immediate is consumed downstream by the PC and data-stack datapath.
    assign unused_imm    = ^ir_reg[IMM_W-1:3];
    assign InstRetired   = retired_reg;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= FETCH;
            ir_reg      <= '0;
            retired_reg <= '0;
        end else if (!Stall) begin
            case (state_reg)
                FETCH: begin
                    ir_reg    <= inst;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    if (opcode == OP_HALT)
                        state_reg <= HALT;
                    else if (opcode > OP_RET)
                        state_reg <= FAULT;
                    else
                        state_reg <= EXEC;
                end
                EXEC: begin
                    if (call_overflow) begin
                        state_reg <= FAULT;
                    end else begin
                        state_reg   <= FETCH;
                        retired_reg <= retired_reg + 1'b1;
                    end
                end
                HALT:    state_reg <= HALT;
                FAULT:   state_reg <= FAULT;
                default: state_reg <= FAULT;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        PCControl = 3'd0;
        RStackOP  = 2'd0;
        DStackOP  = 2'd0;
        ALUOp     = 3'd0;
        DSel      = 1'b0;
        Halted    = (state_reg == HALT);
        Fault     = (state_reg == FAULT);
        case (state_reg)
            FETCH: begin
                PCWrite   = 1'b1;
                PCControl = 3'd4;
            end
            EXEC: begin
                case (opcode)
                    OP_PUSHI: begin
                        DStackOP = 2'd1;
                        DSel     = 1'b1;
                    end
                    OP_ALU: begin
                        DStackOP = 2'd3;
                        ALUOp    = ir_reg[2:0];
                    end
                    OP_POP: DStackOP = 2'd2;
                    OP_DUP: DStackOP = 2'd1;
                    OP_JMP: begin
                        PCWrite   = 1'b1;
                        PCControl = 3'd2;
                    end
                    OP_BZ: begin
                        DStackOP = 2'd2;
                        if (Zero) begin
                            PCWrite   = 1'b1;
                            PCControl = 3'd2;
                        end
                    end
                    OP_CALL: begin
                        // A return-stack overflow turns CALL into a silent trap.
                        if (!Overflow) begin
                            RStackOP  = 2'd1;
                            PCWrite   = 1'b1;
                            PCControl = 3'd2;
                        end
                    end
                    OP_RET: begin
                        RStackOP  = 2'd3;
                        PCWrite   = 1'b1;
                        PCControl = 3'd0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (Stall) begin
            PCWrite  = 1'b0;
            RStackOP = 2'd0;
            DStackOP = 2'd0;
        end
        // Outputs are combinational, so mask them while Reset is held low.
        if (!Reset) begin
            PCWrite   = 1'b0;
            PCControl = 3'd0;
            RStackOP  = 2'd0;
            DStackOP  = 2'd0;
            ALUOp     = 3'd0;
            DSel      = 1'b0;
            Halted    = 1'b0;
            Fault     = 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_control_unit.sv
// Scoreboard bench for stack_control_unit: stimulus queues the hand-computed output set
// for each cycle, a negedge monitor pops and compares it against the live outputs.
module tb_stack_control_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic        Overflow = 1'b0;
    logic        Zero = 1'b0;
    logic        Stall = 1'b0;
    logic        PCWrite;
    logic [2:0]  PCControl;
    logic [1:0]  RStackOP;
    logic [1:0]  DStackOP;
    logic [2:0]  ALUOp;
    logic        DSel;
    logic        Halted;
    logic        Fault;
    logic [15:0] InstRetired;

    typedef struct packed {
        logic        pcw;
        logic [2:0]  pcc;
        logic [1:0]  rso;
        logic [1:0]  dso;
        logic [2:0]  alu;
        logic        dsel;
        logic        halted;
        logic        fault;
        logic [15:0] ret;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    stack_control_unit #(.IMM_W(12), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .inst(inst), .Overflow(Overflow), .Zero(Zero),
        .Stall(Stall), .PCWrite(PCWrite), .PCControl(PCControl), .RStackOP(RStackOP),
        .DStackOP(DStackOP), .ALUOp(ALUOp), .DSel(DSel), .Halted(Halted),
        .Fault(Fault), .InstRetired(InstRetired)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic pcw, input logic [2:0] pcc, input logic [1:0] rso,
                                input logic [1:0] dso, input logic [2:0] alu, input logic dsel,
                                input logic h, input logic f, input logic [15:0] r);
        exp_t e;
        e.pcw = pcw; e.pcc = pcc; e.rso = rso; e.dso = dso; e.alu = alu;
        e.dsel = dsel; e.halted = h; e.fault = f; e.ret = r;
        return e;
    endfunction

    function automatic exp_t f_exp(input logic [15:0] r);
        return mk(1'b1, 3'd4, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, r);
    endfunction

    function automatic exp_t z_exp(input logic [15:0] r);
        return mk(1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, r);
    endfunction

    // Called just after a rising edge: apply inputs, queue the expected outputs for this cycle.
    task automatic cyc(input logic [15:0] i, input logic z, input logic o, input logic s,
                       input exp_t e);
        inst = i; Zero = z; Overflow = o; Stall = s;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_inst(input logic [15:0] i, input logic z, input logic o,
                            input exp_t ex, input logic [15:0] r);
        cyc(i, z, o, 1'b0, f_exp(r));
        cyc(i, z, o, 1'b0, z_exp(r));
        cyc(i, z, o, 1'b0, ex);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        exp_t a;
        cycle_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = mk(PCWrite, PCControl, RStackOP, DStackOP, ALUOp, DSel, Halted, Fault,
                   InstRetired);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got pcw=%0d pcc=%0d rso=%0d dso=%0d alu=%0d dsel=%0d h=%0d f=%0d ret=%0d, expected pcw=%0d pcc=%0d rso=%0d dso=%0d alu=%0d dsel=%0d h=%0d f=%0d ret=%0d",
                         cycle_no, a.pcw, a.pcc, a.rso, a.dso, a.alu, a.dsel, a.halted,
                         a.fault, a.ret, e.pcw, e.pcc, e.rso, e.dso, e.alu, e.dsel,
                         e.halted, e.fault, e.ret);
            end else begin
                $display("cycle %0d ok: inst=%h pcw=%0d pcc=%0d rso=%0d dso=%0d alu=%0d dsel=%0d h=%0d f=%0d ret=%0d",
                         cycle_no, inst, a.pcw, a.pcc, a.rso, a.dso, a.alu, a.dsel,
                         a.halted, a.fault, a.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge CLK);
        #1;
        // Reset held low: everything zero.
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        Reset = 1'b1;

        // NOP stream: fetch strobe every third cycle, four retirements.
        for (int k = 0; k < 4; k++)
            run_inst(16'h0000, 1'b0, 1'b0, z_exp(16'(k)), 16'(k));

        // Data-stack instructions.
        run_inst(16'h1005, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'd4), 16'd4);
        run_inst(16'h2000, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 16'd5), 16'd5);
        run_inst(16'h2005, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd3, 3'd5, 1'b0, 1'b0, 1'b0, 16'd6), 16'd6);
        run_inst(16'h4000, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd1, 3'd0, 1'b0, 1'b0, 1'b0, 16'd7), 16'd7);
        run_inst(16'h3000, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 16'd8), 16'd8);

        // CALL / RET.
        run_inst(16'h7010, 1'b0, 1'b0, mk(1'b1, 3'd2, 2'd1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd9), 16'd9);
        run_inst(16'h8000, 1'b0, 1'b0, mk(1'b1, 3'd0, 2'd3, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd10), 16'd10);

        // BZ not taken / taken, plain JMP.
        run_inst(16'h6008, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 16'd11), 16'd11);
        run_inst(16'h6008, 1'b1, 1'b0, mk(1'b1, 3'd2, 2'd0, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0, 16'd12), 16'd12);
        run_inst(16'h5008, 1'b0, 1'b0, mk(1'b1, 3'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd13), 16'd13);

        // JMP stalled four cycles in EXEC, fires once after release.
        cyc(16'h5008, 1'b0, 1'b0, 1'b0, f_exp(16'd14));
        cyc(16'h5008, 1'b0, 1'b0, 1'b0, z_exp(16'd14));
        for (int k = 0; k < 4; k++)
            cyc(16'h5008, 1'b0, 1'b0, 1'b1, mk(1'b0, 3'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd14));
        cyc(16'h5008, 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd2, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd14));

        // Stall in FETCH: the stalled word (JMP) must not be latched, PUSHI is.
        cyc(16'h5008, 1'b0, 1'b0, 1'b1, mk(1'b0, 3'd4, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd15));
        run_inst(16'h1005, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0, 1'b0, 16'd15), 16'd15);

        // Reset asserted during DECODE of an ALU op aborts it.
        cyc(16'h2003, 1'b0, 1'b0, 1'b0, f_exp(16'd16));
        Reset = 1'b0;
        cyc(16'h2003, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        Reset = 1'b1;
        run_inst(16'h2003, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd3, 3'd3, 1'b0, 1'b0, 1'b0, 16'd0), 16'd0);

        // CALL with return-stack overflow: no writes, FAULT, no retire.
        run_inst(16'h7010, 1'b0, 1'b1, z_exp(16'd1), 16'd1);
        for (int k = 0; k < 3; k++)
            cyc(16'h0000, 1'b1, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'd1));

        // Illegal opcodes 9 and 14 trap.
        Reset = 1'b0;
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        Reset = 1'b1;
        cyc(16'h9000, 1'b0, 1'b0, 1'b0, f_exp(16'd0));
        cyc(16'h9000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        cyc(16'h1005, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0));
        Reset = 1'b0;
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        Reset = 1'b1;
        cyc(16'hE000, 1'b0, 1'b0, 1'b0, f_exp(16'd0));
        cyc(16'hE000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0));

        // HALT is absorbing.
        Reset = 1'b0;
        cyc(16'h0000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        Reset = 1'b1;
        cyc(16'hF000, 1'b0, 1'b0, 1'b0, f_exp(16'd0));
        cyc(16'hF000, 1'b0, 1'b0, 1'b0, z_exp(16'd0));
        for (int k = 0; k < 3; k++)
            cyc(16'h5008, 1'b1, 1'b0, 1'b0, mk(1'b0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0));

        // Every queued expectation must have been consumed by the monitor.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++)
            @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
